// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline stall/flush controller with shared-RAM arbitration and
//            load-use / taken-branch hazard handling. Optional statistics
//            counters are enabled by defining PIPE_CTRL_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int RAM_CYCLES = 2
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        mem_ram_req,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd_addr,
    input  logic [3:0]  id_rs_addr,
    input  logic [3:0]  id_rt_addr,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        id_branch_taken,
    output logic        pc_pause,
    output logic        ii_PC_pause,
    output logic        ii_PC_clear,
    output logic        ie_pause,
    output logic        ie_clear,
    output logic        em_pause,
    output logic        ram_sel,
    output logic [15:0] stat_stall_cnt,
    output logic [15:0] stat_flush_cnt
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

    localparam logic [2:0] c_REMAIN_INIT = 3'(RAM_CYCLES - 1);
    localparam logic       c_SINGLE      = (RAM_CYCLES == 1);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [2:0] r_remain;
    logic [2:0] w_remain_nxt;

    logic w_access;
    logic w_last;
    logic w_freeze;
    logic w_load_use;

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_state  <= S_RUN;
            r_remain <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    // Requests seen while in DATA are ignored; a still-pending request is
    // picked up again on the first RUN cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        case (r_state)
            S_RUN: begin
                if (mem_ram_req && !c_SINGLE) begin
                    w_state_nxt  = S_DATA;
                    w_remain_nxt = c_REMAIN_INIT;
                end
            end
            S_DATA: begin
                w_remain_nxt = r_remain - 3'd1;
                if (r_remain == 3'd1) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt  = S_RUN;
                w_remain_nxt = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_access   = (r_state == S_DATA) || ((r_state == S_RUN) && mem_ram_req);
        w_last     = ((r_state == S_DATA) && (r_remain == 3'd1)) ||
                     ((r_state == S_RUN) && mem_ram_req && c_SINGLE);
        w_freeze   = w_access && !w_last;
        w_load_use = ex_mem_read &&
                     ((id_rs_used && (ex_rd_addr == id_rs_addr)) ||
                      (id_rt_used && (ex_rd_addr == id_rt_addr)));

        pc_pause    = 1'b0;
        ii_PC_pause = 1'b0;
        ii_PC_clear = 1'b0;
        ie_pause    = 1'b0;
        ie_clear    = 1'b0;
        em_pause    = 1'b0;
        ram_sel     = 1'b0;

        // Outputs are held low for the whole time reset is asserted.
        if (rst) begin
            ram_sel = w_access;
            if (w_freeze) begin
                pc_pause    = 1'b1;
                ii_PC_pause = 1'b1;
                ie_pause    = 1'b1;
                em_pause    = 1'b1;
            end else if (w_load_use) begin
                pc_pause    = 1'b1;
                ii_PC_pause = 1'b1;
                ie_clear    = 1'b1;
            end else if (id_branch_taken) begin
                ii_PC_clear = 1'b1;
            end else if (w_last) begin
                pc_pause    = 1'b1;
                ii_PC_clear = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_STAT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating counters: they stick at 0xFFFF rather than wrap.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (pc_pause && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (ii_PC_clear && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stat_stall_cnt = r_stall_cnt;
    assign stat_flush_cnt = r_flush_cnt;
`else
    assign stat_stall_cnt = 16'd0;
    assign stat_flush_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Scoreboard bench for pipe_hazard_ctrl with RAM_CYCLES = 1, 3, 4
//            instances sharing one stimulus stream (PIPE_CTRL_STAT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk_50MHz = 1'b0;
    logic        rst;
    logic        mem_ram_req;
    logic        ex_mem_read;
    logic [3:0]  ex_rd_addr;
    logic [3:0]  id_rs_addr;
    logic [3:0]  id_rt_addr;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        id_branch_taken;

    logic        pc_pause    [3];
    logic        ii_PC_pause [3];
    logic        ii_PC_clear [3];
    logic        ie_pause    [3];
    logic        ie_clear    [3];
    logic        em_pause    [3];
    logic        ram_sel     [3];
    logic [15:0] stall_cnt   [3];
    logic [15:0] flush_cnt   [3];

    always #5 clk_50MHz = ~clk_50MHz;

    // Instance 0: RAM_CYCLES=1, instance 1: RAM_CYCLES=3, instance 2: RAM_CYCLES=4
    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_hazard_ctrl #(
            .RAM_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk_50MHz       (clk_50MHz),
            .rst             (rst),
            .mem_ram_req     (mem_ram_req),
            .ex_mem_read     (ex_mem_read),
            .ex_rd_addr      (ex_rd_addr),
            .id_rs_addr      (id_rs_addr),
            .id_rt_addr      (id_rt_addr),
            .id_rs_used      (id_rs_used),
            .id_rt_used      (id_rt_used),
            .id_branch_taken (id_branch_taken),
            .pc_pause        (pc_pause[g]),
            .ii_PC_pause     (ii_PC_pause[g]),
            .ii_PC_clear     (ii_PC_clear[g]),
            .ie_pause        (ie_pause[g]),
            .ie_clear        (ie_clear[g]),
            .em_pause        (em_pause[g]),
            .ram_sel         (ram_sel[g]),
            .stat_stall_cnt  (stall_cnt[g]),
            .stat_flush_cnt  (flush_cnt[g])
        );
    end

    // Vector order: pc_pause, ii_PC_pause, ii_PC_clear, ie_pause, ie_clear, em_pause, ram_sel
    localparam logic [6:0] c_ZERO = 7'b0000000;
    localparam logic [6:0] c_FRZ  = 7'b1101011;
    localparam logic [6:0] c_LAST = 7'b1010001;
    localparam logic [6:0] c_LU   = 7'b1100100;
    localparam logic [6:0] c_BR   = 7'b0010000;
    localparam logic [6:0] c_BRL  = 7'b0010001;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } entry_t;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_errors = 0;

    function automatic logic [15:0] actual(input int sel);
        logic [15:0] v;
        v = 16'd0;
        if (sel <= 2) begin
            v[6:0] = {pc_pause[sel], ii_PC_pause[sel], ii_PC_clear[sel],
                      ie_pause[sel], ie_clear[sel], em_pause[sel], ram_sel[sel]};
        end else if (sel == 3) begin
            v = stall_cnt[1];
        end else begin
            v = flush_cnt[1];
        end
        return v;
    endfunction

    // Monitor: drains every expectation queued during the current cycle.
    always @(negedge clk_50MHz) begin
        while (sb.size() > 0) begin
            entry_t  e;
            logic [15:0] a;
            e = sb.pop_front();
            a = actual(e.sel);
            n_checks++;
            if (a !== e.exp) begin
                n_errors++;
                $display("FAIL %s (sel %0d): got %h expected %h", e.name, e.sel, a, e.exp);
            end
        end
    end

    task automatic push(input string nm, input int sel, input logic [15:0] e);
        sb.push_back('{name: nm, sel: sel, exp: e});
    endtask

    task automatic chk_all(input string nm, input logic [6:0] e1,
                           input logic [6:0] e3, input logic [6:0] e4);
        push({nm, "_rc1"}, 0, {9'd0, e1});
        push({nm, "_rc3"}, 1, {9'd0, e3});
        push({nm, "_rc4"}, 2, {9'd0, e4});
    endtask

    task automatic tick;
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic idle_inputs;
        mem_ram_req     = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rd_addr      = 4'h0;
        id_rs_addr      = 4'h0;
        id_rt_addr      = 4'h0;
        id_rs_used      = 1'b0;
        id_rt_used      = 1'b0;
        id_branch_taken = 1'b0;
    endtask

    task automatic set_load_use;
        ex_mem_read = 1'b1;
        ex_rd_addr  = 4'h3;
        id_rs_addr  = 4'h3;
        id_rs_used  = 1'b1;
    endtask

    initial begin
        #1_500_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        idle_inputs();
        rst         = 1'b0;
        mem_ram_req = 1'b1;
        tick();

        chk_all("reset", c_ZERO, c_ZERO, c_ZERO);
        push("reset_stall", 3, 16'd0);
        push("reset_flush", 4, 16'd0);
        tick();

        // First edge after release with a request pending
        rst = 1'b1;
        chk_all("acc0", c_LAST, c_FRZ, c_FRZ);
        tick();
        mem_ram_req = 1'b0;
        chk_all("acc1", c_ZERO, c_FRZ, c_FRZ);
        tick();
        chk_all("acc2", c_ZERO, c_LAST, c_FRZ);
        tick();
        chk_all("acc3", c_ZERO, c_ZERO, c_LAST);
        tick();
        chk_all("acc4", c_ZERO, c_ZERO, c_ZERO);
        tick();

        // Load-use variants
        set_load_use();
        chk_all("lu_rs", c_LU, c_LU, c_LU);
        tick();
        id_rs_used = 1'b0;
        chk_all("lu_rs_unused", c_ZERO, c_ZERO, c_ZERO);
        tick();
        id_rt_addr = 4'h3;
        id_rt_used = 1'b1;
        chk_all("lu_rt", c_LU, c_LU, c_LU);
        tick();
        ex_rd_addr = 4'h5;
        chk_all("lu_nomatch", c_ZERO, c_ZERO, c_ZERO);
        tick();

        // Load-use suppresses a same-cycle branch; branch then re-presented
        idle_inputs();
        set_load_use();
        id_branch_taken = 1'b1;
        chk_all("lu_br", c_LU, c_LU, c_LU);
        tick();
        ex_mem_read = 1'b0;
        chk_all("br", c_BR, c_BR, c_BR);
        tick();

        // Branch in a single-cycle access; freeze masks it on longer accesses
        idle_inputs();
        mem_ram_req     = 1'b1;
        id_branch_taken = 1'b1;
        chk_all("br_acc", c_BRL, c_FRZ, c_FRZ);
        tick();
        idle_inputs();
        chk_all("data_a", c_ZERO, c_FRZ, c_FRZ);
        tick();
        chk_all("data_b", c_ZERO, c_LAST, c_FRZ);

        // Reset in the middle of DATA (RAM_CYCLES=4 at remain=2)
        @(negedge clk_50MHz);
        #1;
        rst         = 1'b0;
        mem_ram_req = 1'b1;
        chk_all("rst_mid", c_ZERO, c_ZERO, c_ZERO);
        tick();
        mem_ram_req = 1'b0;
        rst         = 1'b1;
        chk_all("post_rst", c_ZERO, c_ZERO, c_ZERO);
        tick();

        // Back-to-back accesses with the request held
        mem_ram_req = 1'b1;
        chk_all("b2b0", c_LAST, c_FRZ,  c_FRZ);
        tick();
        chk_all("b2b1", c_LAST, c_FRZ,  c_FRZ);
        tick();
        chk_all("b2b2", c_LAST, c_LAST, c_FRZ);
        tick();
        chk_all("b2b3", c_LAST, c_FRZ,  c_LAST);
        tick();
        mem_ram_req = 1'b0;
        chk_all("b2b4", c_ZERO, c_FRZ,  c_ZERO);
        tick();
        chk_all("b2b5", c_ZERO, c_LAST, c_ZERO);
        tick();
        chk_all("b2b6", c_ZERO, c_ZERO, c_ZERO);
        tick();

        // Statistics: 3 stall cycles then 2 flush cycles after a fresh reset
        @(negedge clk_50MHz);
        #1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        push("stat_clr_stall", 3, 16'd0);
        push("stat_clr_flush", 4, 16'd0);
        set_load_use();
        tick();
        tick();
        tick();
        idle_inputs();
        id_branch_taken = 1'b1;
        tick();
        tick();
        idle_inputs();
`ifdef PIPE_CTRL_STAT_EN
        push("stat_stall", 3, 16'd3);
        push("stat_flush", 4, 16'd2);
        tick();
        set_load_use();
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        idle_inputs();
        push("stat_sat_stall", 3, 16'hFFFF);
        push("stat_sat_flush", 4, 16'd2);
`else
        push("stat_stall_off", 3, 16'd0);
        push("stat_flush_off", 4, 16'd0);
`endif
        tick();

        @(negedge clk_50MHz);
        #1;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the pause and clear inputs of the PC, IF_ID, ID_EX and EX_MEM registers. It arbitrates the single shared RAM between instruction fetch and MEM-stage data access, running a multi-cycle access FSM. It also detects load-use and taken-branch hazards.

## Interface
- `RAM_CYCLES`, default 2: cycles per data access on the shared RAM; legal range 1..8.
- `clk_50MHz` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_ram_req` in 1: the MEM stage holds a load or store needing the shared RAM.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_rd_addr` in 4: destination register of the EX instruction.
- `id_rs_addr`, `id_rt_addr` in 4 each: source registers of the ID instruction.
- `id_rs_used`, `id_rt_used` in 1 each: the matching source is actually read.
- `id_branch_taken` in 1: the ID stage resolved a taken branch or jump.
- `pc_pause` out 1: the PC holds its value.
- `ii_PC_pause` out 1: IF_ID holds its value.
- `ii_PC_clear` out 1: IF_ID loads a bubble.
- `ie_pause` out 1: ID_EX holds.
- `ie_clear` out 1: ID_EX loads a bubble.
- `em_pause` out 1: EX_MEM holds.
- `ram_sel` out 1: RAM owner; 0 = instruction fetch, 1 = data access.
- `stat_stall_cnt` out 16: pipeline stall cycle counter (see Configuration).
- `stat_flush_cnt` out 16: IF_ID flush counter (see Configuration).
- All pause and clear outputs are active-high (1 = enable).

## Operation
- FSM states: RUN and DATA. A 3-bit counter `remain` holds the number of access cycles still to go.
- **RUN**
  - When `mem_ram_req`=1, the current cycle is access cycle 0 and `ram_sel`=1.
  - If `RAM_CYCLES`>1, go to DATA with `remain`=`RAM_CYCLES`-1.
  - If `RAM_CYCLES`=1, stay in RUN.
- **DATA**
  - `ram_sel`=1 and `remain` decrements each cycle.
  - Return to RUN after the cycle in which `remain`=1.
  - `mem_ram_req` is ignored while in DATA.
- **Freeze cycle**: any access cycle other than the last.
  - `pc_pause`, `ii_PC_pause`, `ie_pause` and `em_pause` are all 1.
  - All clears are 0 and the hazard logic is masked.
- **Last access cycle**: cycle 0 when `RAM_CYCLES`=1.
  - The fetch slot was stolen, so `pc_pause`=1 and `ii_PC_clear`=1.
  - EX/MEM advance and the hazard logic is evaluated.
- **Load-use**: `ex_mem_read` & ((`id_rs_used` & `ex_rd_addr`==`id_rs_addr`) | (`id_rt_used` & `ex_rd_addr`==`id_rt_addr`)).
  - Drives `pc_pause`=1, `ii_PC_pause`=1, `ie_clear`=1.
  - `id_branch_taken` is suppressed for that cycle.
- **Taken branch** with no load-use: `ii_PC_clear`=1 and `pc_pause`=0, so the PC loads the target.
  - This also applies in the last access cycle, overriding that cycle's `pc_pause`.
- **Priority**: freeze > load-use > branch > last-cycle bubble > run (all outputs 0).
- All pause/clear outputs are combinational from state, `remain` and inputs. `ram_sel` = (RUN & `mem_ram_req`) | DATA.

## Timing
- While `rst`=0:
  - state is RUN and `remain`=0;
  - all pause/clear outputs and `ram_sel` are forced to 0;
  - stat counters are 0.
- Reset asserted in the middle of DATA aborts the access immediately. After release the FSM is in RUN.
- Pipeline registers sample the outputs on the same rising edge as the hazard condition, giving zero-cycle latency.
- A data access holds the pipeline for `RAM_CYCLES`-1 freeze cycles plus 1 bubble cycle.
- A load-use costs 1 bubble. A taken branch costs 1 flushed slot.
- If `mem_ram_req` is still 1 on the first RUN cycle after DATA, a new access starts; back-to-back accesses are legal.

## Configuration
- `PIPE_CTRL_STAT_EN` defined:
  - `stat_stall_cnt` counts cycles with `pc_pause`=1;
  - `stat_flush_cnt` counts cycles with `ii_PC_clear`=1;
  - both are 16-bit and saturate at 0xFFFF, with no wrap.
- Not defined: both ports exist and are tied to 0, and no counter flops are synthesized.

## Test plan
- Reset asserted with `mem_ram_req`=1: all outputs 0. After release, the first rising edge with `mem_ram_req`=1 gives `ram_sel`=1.
- `RAM_CYCLES`=3, single `mem_ram_req` pulse: 2 cycles with all four pauses at 1, then 1 cycle with `pc_pause`=1 and `ii_PC_clear`=1, then all outputs 0 and `ram_sel`=0.
- `ex_mem_read`=1, `ex_rd_addr`=4'h3, `id_rs_addr`=4'h3, `id_rs_used`=1: one cycle with `pc_pause`, `ii_PC_pause` and `ie_clear` at 1. With `id_rs_used`=0, no stall.
- Load-use and `id_branch_taken` in the same cycle: `ii_PC_clear`=0 and `ie_clear`=1. The branch, re-presented the next cycle, gives `ii_PC_clear`=1 and `pc_pause`=0.
- `RAM_CYCLES`=1 with `id_branch_taken`=1 in the access cycle: `pc_pause`=0, `ii_PC_clear`=1, `ram_sel`=1.
- `rst` pulsed low in the middle of DATA (`RAM_CYCLES`=4, `remain`=2): outputs drop to 0 immediately. With `PIPE_CTRL_STAT_EN`, 70000 forced stall cycles read back `stat_stall_cnt`=0xFFFF.
